// File: rtl/pe_array_row_feeder.sv
// rtl/pe_array_row_feeder.sv - tags weight/activation vectors and fans them into per-row FIFOs
module pe_array_row_feeder #(
    parameter int NUM_ROWS   = 2,
    parameter int NUM_COLS   = 2,
    parameter int BIT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BIT_WIDTH-1:0] i_vec_data     [NUM_ROWS],
    input  logic                 i_vec_last,
    input  logic                 i_vec_val,
    output logic                 o_vec_rdy,
    output logic [BIT_WIDTH:0]   o_msg_send_msg [NUM_ROWS],
    output logic [NUM_ROWS-1:0]  o_msg_send_val,
    input  logic [NUM_ROWS-1:0]  i_msg_send_rdy,
    output logic                 o_weight_phase,
    output logic                 o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] W_LAST    = CW'(NUM_COLS - 1);
    localparam logic [0:0]    LOAD_W    = 1'b0;
    localparam logic [0:0]    STREAM_A  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [CW-1:0]  w_cnt_q, w_cnt_d;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q [NUM_ROWS];
    logic [AW-1:0]  rd_ptr_d [NUM_ROWS];
    logic [AW:0]    cnt_q    [NUM_ROWS];
    logic [AW:0]    cnt_d    [NUM_ROWS];
    logic [BIT_WIDTH:0] mem_q [NUM_ROWS][FIFO_DEPTH];

    logic                acc;
    logic                tag;
    logic                any_full;
    logic                any_nempty;
    logic [NUM_ROWS-1:0] pop;

    // Ready looks only at registered counts, so a pop this cycle cannot free a full row early.
    always_comb begin
        any_full   = 1'b0;
        any_nempty = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (cnt_q[r] == CNT_FULL) any_full = 1'b1;
            if (cnt_q[r] != '0)       any_nempty = 1'b1;
        end
    end

    assign o_vec_rdy      = i_rst_n & ~any_full;
    assign acc            = i_vec_val & o_vec_rdy;
    assign tag            = (state_q == LOAD_W);
    assign o_weight_phase = (state_q == LOAD_W);
    assign o_busy         = any_nempty;

    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            o_msg_send_val[r] = (cnt_q[r] != '0);
            o_msg_send_msg[r] = mem_q[r][rd_ptr_q[r]];
            pop[r]            = o_msg_send_val[r] & i_msg_send_rdy[r];
            rd_ptr_d[r]       = pop[r] ? rd_ptr_q[r] + AW'(1) : rd_ptr_q[r];
            case ({acc, pop[r]})
                2'b10:   cnt_d[r] = cnt_q[r] + (AW+1)'(1);
                2'b01:   cnt_d[r] = cnt_q[r] - (AW+1)'(1);
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        w_cnt_d = w_cnt_q;
        if (acc) begin
            if (state_q == LOAD_W) begin
                if (w_cnt_q == W_LAST) begin
                    state_d = STREAM_A;
                    w_cnt_d = '0;
                end else begin
                    w_cnt_d = w_cnt_q + CW'(1);
                end
            end else if (i_vec_last) begin
                state_d = LOAD_W;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= LOAD_W;
            w_cnt_q  <= '0;
            wr_ptr_q <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                rd_ptr_q[r] <= '0;
                cnt_q[r]    <= '0;
                for (int i = 0; i < FIFO_DEPTH; i++) mem_q[r][i] <= '0;
            end
        end else begin
            state_q <= state_d;
            w_cnt_q <= w_cnt_d;
            if (acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            for (int r = 0; r < NUM_ROWS; r++) begin
                rd_ptr_q[r] <= rd_ptr_d[r];
                cnt_q[r]    <= cnt_d[r];
                if (acc) mem_q[r][wr_ptr_q] <= {tag, i_vec_data[r]};
            end
        end
    end

endmodule

// File: tb/tb_pe_array_row_feeder.sv
// tb/tb_pe_array_row_feeder.sv - directed vector bench for pe_array_row_feeder
module tb_pe_array_row_feeder;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] vec_data [2];
    logic       i_vec_last;
    logic       i_vec_val;
    logic       o_vec_rdy;
    logic [8:0] msg [2];
    logic [1:0] send_val;
    logic [1:0] send_rdy;
    logic       o_weight_phase;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic       last;
        logic [8:0] e0;
        logic [8:0] e1;
        logic       wp;
    } vec_t;

    vec_t tbl [7];

    pe_array_row_feeder #(
        .NUM_ROWS(2), .NUM_COLS(2), .BIT_WIDTH(8), .FIFO_DEPTH(4)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_vec_data     (vec_data),
        .i_vec_last     (i_vec_last),
        .i_vec_val      (i_vec_val),
        .o_vec_rdy      (o_vec_rdy),
        .o_msg_send_msg (msg),
        .o_msg_send_val (send_val),
        .i_msg_send_rdy (send_rdy),
        .o_weight_phase (o_weight_phase),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic l);
        vec_data[0] = a;
        vec_data[1] = b;
        i_vec_last  = l;
        i_vec_val   = 1'b1;
        chk("push_rdy", {31'd0, o_vec_rdy}, 32'd1);
        tick();
        i_vec_val   = 1'b0;
    endtask

    initial begin
        int n;
        logic acc;
        logic [7:0] k8;

        tbl[0] = '{8'h01, 8'h02, 1'b0, 9'h101, 9'h102, 1'b1};
        tbl[1] = '{8'h03, 8'h04, 1'b0, 9'h103, 9'h104, 1'b0};
        tbl[2] = '{8'h10, 8'h20, 1'b0, 9'h010, 9'h020, 1'b0};
        tbl[3] = '{8'h30, 8'h40, 1'b1, 9'h030, 9'h040, 1'b1};
        tbl[4] = '{8'h05, 8'h06, 1'b1, 9'h105, 9'h106, 1'b1};
        tbl[5] = '{8'h07, 8'h08, 1'b1, 9'h107, 9'h108, 1'b0};
        tbl[6] = '{8'h55, 8'h66, 1'b1, 9'h055, 9'h066, 1'b1};

        i_rst_n     = 1'b0;
        vec_data[0] = '0;
        vec_data[1] = '0;
        i_vec_last  = 1'b0;
        i_vec_val   = 1'b0;
        send_rdy    = 2'b00;

        // reset held for 3 cycles
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_rdy",  {31'd0, o_vec_rdy}, 32'd0);
            chk("rst_val",  {30'd0, send_val}, 32'd0);
            chk("rst_wp",   {31'd0, o_weight_phase}, 32'd1);
            chk("rst_busy", {31'd0, o_busy}, 32'd0);
        end
        chk("rst_msg0", {23'd0, msg[0]}, 32'd0);
        i_rst_n = 1'b1;
        tick();
        chk("rel_rdy", {31'd0, o_vec_rdy}, 32'd1);

        // frame tagging and last-ignored-in-LOAD_W, sinks always ready
        send_rdy = 2'b11;
        for (int i = 0; i < 7; i++) begin
            push(tbl[i].d0, tbl[i].d1, tbl[i].last);
            chk($sformatf("tbl%0d_val", i),  {30'd0, send_val}, 32'd3);
            chk($sformatf("tbl%0d_msg0", i), {23'd0, msg[0]}, {23'd0, tbl[i].e0});
            chk($sformatf("tbl%0d_msg1", i), {23'd0, msg[1]}, {23'd0, tbl[i].e1});
            chk($sformatf("tbl%0d_wp", i),   {31'd0, o_weight_phase}, {31'd0, tbl[i].wp});
        end
        tick();
        chk("tbl_drained", {31'd0, o_busy}, 32'd0);

        // fill with sinks stalled
        send_rdy = 2'b00;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            vec_data[0] = 8'hA0 + 8'(n);
            vec_data[1] = 8'hB0 + 8'(n);
            i_vec_last  = 1'b0;
            i_vec_val   = 1'b1;
            acc = o_vec_rdy;
            tick();
            if (acc) n++;
        end
        chk("fill_count", n, 32'd4);
        chk("fill_rdy",   {31'd0, o_vec_rdy}, 32'd0);
        chk("fill_busy",  {31'd0, o_busy}, 32'd1);
        vec_data[0] = 8'hA4;
        vec_data[1] = 8'hB4;
        send_rdy = 2'b11;
        tick();
        send_rdy = 2'b00;
        chk("recover_rdy", {31'd0, o_vec_rdy}, 32'd1);
        tick();
        i_vec_val = 1'b0;
        chk("refill_rdy", {31'd0, o_vec_rdy}, 32'd0);
        chk("refill_head0", {23'd0, msg[0]}, 32'h1A1);
        send_rdy = 2'b11;
        for (int k = 1; k < 5; k++) begin
            k8 = 8'(k);
            chk($sformatf("drain%0d_val", k),  {30'd0, send_val}, 32'd3);
            chk($sformatf("drain%0d_msg0", k), {23'd0, msg[0]}, {23'd0, (k == 1), 8'hA0 + k8});
            chk($sformatf("drain%0d_msg1", k), {23'd0, msg[1]}, {23'd0, (k == 1), 8'hB0 + k8});
            tick();
        end
        chk("drain_empty", {30'd0, send_val}, 32'd0);
        chk("drain_wp",    {31'd0, o_weight_phase}, 32'd0);

        // independent drain: row0 ready, row1 stalled
        send_rdy = 2'b00;
        for (int k = 0; k < 3; k++) push(8'hC0 + 8'(k), 8'hD0 + 8'(k), 1'b0);
        send_rdy = 2'b01;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ind%0d_val", k),  {30'd0, send_val}, 32'd3);
            chk($sformatf("ind%0d_msg0", k), {23'd0, msg[0]}, {24'd0, 8'hC0 + 8'(k)});
            chk($sformatf("ind%0d_msg1", k), {23'd0, msg[1]}, 32'h0D0);
            tick();
        end
        chk("ind_val_after", {30'd0, send_val}, 32'd2);
        chk("ind_msg1_after", {23'd0, msg[1]}, 32'h0D0);
        send_rdy = 2'b10;
        for (int k = 0; k < 3; k++) tick();
        chk("ind_row1_empty", {30'd0, send_val}, 32'd0);

        // reset mid-frame: 1 weight counted, 2 entries queued
        send_rdy = 2'b00;
        push(8'hE0, 8'hF0, 1'b1);
        push(8'hE1, 8'hF1, 1'b0);
        chk("mid_wp",   {31'd0, o_weight_phase}, 32'd1);
        chk("mid_val",  {30'd0, send_val}, 32'd3);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_val",  {30'd0, send_val}, 32'd0);
        chk("mid_rst_wp",   {31'd0, o_weight_phase}, 32'd1);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_rdy",  {31'd0, o_vec_rdy}, 32'd0);
        chk("mid_rst_msg0", {23'd0, msg[0]}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        #1;
        push(8'h11, 8'h22, 1'b0);
        chk("post_msg0", {23'd0, msg[0]}, 32'h111);
        chk("post_msg1", {23'd0, msg[1]}, 32'h122);
        chk("post_wp",   {31'd0, o_weight_phase}, 32'd1);
        push(8'h33, 8'h44, 1'b0);
        chk("post2_wp",   {31'd0, o_weight_phase}, 32'd0);
        chk("post2_head", {23'd0, msg[0]}, 32'h111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
